// File: rtl/obstacle_field_gen.sv
// Obstacle-row generator for the dino runner: LFSR-driven spawns, min gap.
// Optional air row via `define AIR_OBSTACLE_EN (off by default).
module obstacle_field_gen #(
  parameter int          WIDTH     = 8,
  parameter int          MAX_LEN   = 2,
  parameter int          MIN_GAP   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             clear,
  input  logic [3:0]       density,
  output logic [WIDTH-1:0] down,
`ifdef AIR_OBSTACLE_EN
  output logic [WIDTH-1:0] up,
`endif
  output logic             passed,
  output logic [15:0]      passed_count
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [0:0] S_GAP  = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [3:0] GAP_MIN = 4'(MIN_GAP);
  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  logic [15:0] lfsr;
  logic        fb;
  logic        step;

  logic [0:0]  state;
  logic [0:0]  state_n;
  logic [3:0]  gap_cnt;
  logic [3:0]  gap_n;
  logic [1:0]  len_rem;
  logic [1:0]  len_n;
  logic [1:0]  len_m1;

  logic        air;
  logic        ins_dn;
  logic        ins_up;

  logic        pass_dn;
  logic        pass_up;
  logic        pass_any;
  logic [1:0]  pass_inc;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_n;

  assign step = tick & run;
  assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef AIR_OBSTACLE_EN
  logic [WIDTH-1:0] up_q;
  assign up      = up_q;
  assign air     = lfsr[8];
  assign pass_up = up_q[WIDTH-1] & ~up_q[WIDTH-2];
`else
  assign air     = 1'b0;
  assign pass_up = 1'b0;
`endif

  assign pass_dn  = down[WIDTH-1] & ~down[WIDTH-2];
  assign pass_any = pass_dn | pass_up;
  assign pass_inc = {1'b0, pass_dn} + {1'b0, pass_up};
  assign cnt_sum  = {1'b0, passed_count} + {15'd0, pass_inc};
  assign cnt_n    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // spawn decision and gap/length bookkeeping from the pre-step lfsr
  always_comb begin
    ins_dn  = 1'b0;
    ins_up  = 1'b0;
    state_n = state;
    gap_n   = gap_cnt;
    len_n   = len_rem;
    len_m1  = 2'(lfsr[7:4] % LEN_MAX);
    case (state)
      S_GAP: begin
        if (gap_cnt < GAP_MIN) begin
          gap_n = gap_cnt + 4'd1;
        end else if (lfsr[3:0] < density) begin
          if (air) begin
            ins_up = 1'b1;
            gap_n  = 4'd0;
          end else begin
            ins_dn = 1'b1;
            if (len_m1 == 2'd0) begin
              gap_n = 4'd0;
            end else begin
              state_n = S_EMIT;
              len_n   = len_m1;
            end
          end
        end
      end
      S_EMIT: begin
        ins_dn = 1'b1;
        len_n  = len_rem - 2'd1;
        if (len_rem == 2'd1) begin
          state_n = S_GAP;
          gap_n   = 4'd0;
        end
      end
      default: begin
        state_n = S_GAP;
        gap_n   = 4'd0;
        len_n   = 2'd0;
      end
    endcase
  end

  // lfsr advances on every step; clear does not reseed it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

  // spawn FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_GAP;
      gap_cnt <= 4'd0;
      len_rem <= 2'd0;
    end else if (clear) begin
      state   <= S_GAP;
      gap_cnt <= 4'd0;
      len_rem <= 2'd0;
    end else if (step) begin
      state   <= state_n;
      gap_cnt <= gap_n;
      len_rem <= len_n;
    end
  end

  // ground row shift toward the player
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      down <= '0;
    end else if (clear) begin
      down <= '0;
    end else if (step) begin
      down <= {down[WIDTH-2:0], ins_dn};
    end
  end

`ifdef AIR_OBSTACLE_EN
  // air row shift, same step as the ground row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q <= '0;
    end else if (clear) begin
      up_q <= '0;
    end else if (step) begin
      up_q <= {up_q[WIDTH-2:0], ins_up};
    end
  end
`else
  logic unused_ins_up;
  assign unused_ins_up = ins_up;
`endif

  // passed pulse and saturating score
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      passed       <= 1'b0;
      passed_count <= 16'd0;
    end else if (clear) begin
      passed       <= 1'b0;
      passed_count <= 16'd0;
    end else if (step) begin
      passed       <= pass_any;
      passed_count <= cnt_n;
    end else begin
      passed       <= 1'b0;
    end
  end

endmodule
